serial_sub: RTL
===============

Name: serial_sub

Overview:
- Multi-cycle, digit-serial unsigned/two's-complement subtractor computing DIFF = A - B - SUB1, processed DIGIT bits per clock with a borrow register carried between digits.
- Inverse-operation companion to the combinational adder wrappers.
- Intended for area-constrained datapaths where a full-width subtract per cycle is not needed.
- Valid/ready handshake on both the operand side and the result side.

Parameters:
- WIDTH, 10, operand and result width in bits.
- DIGIT, 2, bits processed per cycle. WIDTH % DIGIT must be 0; anything else is an elaboration error. N = WIDTH/DIGIT.
- SUB1, 0, when 1 subtract an extra 1 (initial borrow-in = 1). Mirrors the adder's ADD1 option.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- IN_VALID  in  1  operands A/B valid.
- IN_READY  out  1  block can accept operands.
- A  in  WIDTH  minuend.
- B  in  WIDTH  subtrahend.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- DIFF  out  WIDTH  A - B - SUB1, modulo 2^WIDTH.
- BORROW  out  1  1 when A < B + SUB1, treating A and B as unsigned.
- OVF  out  1  signed two's-complement overflow.

Behaviour:
- One clock domain: CLK. Reset is synchronous and active-high on RST.
- Reset (RST high at an edge):
  - state = IDLE; IN_READY = 1; OUT_VALID = 0; DIFF = 0; BORROW = 0; OVF = 0; digit counter = 0.
  - Reset dominates all other inputs.
  - Reset during RUN or DONE discards the operation and produces no result.
- States:
  - IDLE: IN_READY = 1. On IN_VALID & IN_READY at edge t0:
    - latch A and B;
    - carry register = ~SUB1 (computes A + ~B + carry);
    - counter = 0;
    - go to RUN.
  - RUN: IN_READY = 0, OUT_VALID = 0. Each edge processes digit k = counter, bits [k*DIGIT +: DIGIT]:
    - {c, d} = A_k + ~B_k + carry;
    - write d into the DIFF register slice;
    - carry = c;
    - counter++.
    - After the edge processing digit N-1 (edge t0+N), go to DONE.
  - DONE: OUT_VALID = 1; DIFF, BORROW, OVF held stable; IN_READY = 0.
    - On OUT_VALID & OUT_READY, go to IDLE at that edge. OUT_VALID is low in the following cycle.
- Latency: OUT_VALID is first high in the cycle after edge t0+N, i.e. N cycles after the accept edge.
- Throughput: one operation per N+2 cycles minimum, when OUT_READY is held high.
- Result flags:
  - BORROW = ~final_carry.
  - OVF = (A[W-1] != B[W-1]) & (DIFF[W-1] != A[W-1]). The SUB1 borrow is included in DIFF.
- DIFF may show partially updated bits during RUN. Consumers must sample only when OUT_VALID = 1.
- No back-to-back accept: IN_VALID presented in RUN or DONE is ignored and must be held by the source.
- Output registers change only in RUN and at reset.
- DIGIT = WIDTH is legal: N = 1, and OUT_VALID is high 1 cycle after accept.
- Operands are captured at accept. Later changes to A and B have no effect.

Test Plan:
- WIDTH=10, DIGIT=2, SUB1=0: A=300, B=45 accepted at edge t0 -> OUT_VALID first high after edge t0+5; DIFF=255, BORROW=0, OVF=0.
- A=45, B=300 -> DIFF=769, BORROW=1, OVF=0. A=0x1FF, B=0x200 -> DIFF=0x3FF, BORROW=1, OVF=1.
- Backpressure: hold OUT_READY=0 for 3 cycles after OUT_VALID rises -> DIFF, BORROW and OVF stable; IN_READY=0. IN_VALID pulsed with A=1, B=1 during this window is not accepted. OUT_READY=1 -> IDLE on the next edge with IN_READY=1.
- Reset mid-operation: RST high at edge t0+2 -> next cycle IN_READY=1, OUT_VALID=0, DIFF=0. Following operation A=7, B=7 -> DIFF=0, BORROW=0, OVF=0.
- SUB1=1 instance: A=0, B=0 -> DIFF=1023, BORROW=1, OVF=0. A=5, B=2 -> DIFF=2, BORROW=0.
- DIGIT=10 (N=1): A=3, B=4 -> DIFF=1023, BORROW=1, OUT_VALID one cycle after accept. Random sweep of 1000 operand pairs for DIGIT in {1,2,5,10} matches the reference model for A - B - SUB1.

Source files
------------

// File: rtl/serial_sub.sv
// Digit-serial subtractor: DIFF = A - B - SUB1, DIGIT bits per clock, computed as A + ~B + carry
// with a carry (inverted borrow) register threaded between digits.
module serial_sub #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DIGIT = 2,
    parameter bit          SUB1  = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW,
    output logic             OVF
);

    localparam int N  = int'(WIDTH / DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_sub: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   sum;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                a_dig = a_q[k*DIGIT +: DIGIT];
                b_dig = b_q[k*DIGIT +: DIGIT];
            end
        end
        sum = {1'b0, a_dig} + {1'b0, ~b_dig} + {{DIGIT{1'b0}}, carry_q};

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        diff_d      = diff_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (IN_VALID) begin
                    a_d        = A;
                    b_d        = B;
                    carry_d    = ~SUB1;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < N; k++) begin
                    if (cnt_q == CW'(k)) diff_d[k*DIGIT +: DIGIT] = sum[DIGIT-1:0];
                end
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    // Last digit: its top sum bit is DIFF's sign bit.
                    borrow_d    = ~sum[DIGIT];
                    ovf_d       = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (sum[DIGIT-1] ^ a_q[WIDTH-1]);
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            diff_q      <= diff_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign DIFF      = diff_q;
    assign BORROW    = borrow_q;
    assign OVF       = ovf_q;

endmodule
